// File: rtl/div_iter_unit_if.sv
// Execute-stage divider hookup: start/operand/flush controls in, stall/ready/result out.
interface div_iter_unit_if #(
    parameter int WIDTH = 32
);
    logic                 div_startE;
    logic                 div_signedE;
    logic [WIDTH-1:0]     srcaE;
    logic [WIDTH-1:0]     srcbE;
    logic                 flushE;
    logic                 cache_stall;
    logic                 div_stall;
    logic                 div_ready;
    logic [2*WIDTH-1:0]   div_result;

    modport master (
        output div_startE, div_signedE, srcaE, srcbE, flushE, cache_stall,
        input  div_stall, div_ready, div_result
    );

    modport slave (
        input  div_startE, div_signedE, srcaE, srcbE, flushE, cache_stall,
        output div_stall, div_ready, div_result
    );
endinterface

// File: rtl/div_iter_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU; one quotient bit per cycle,
// sign correction applied when the result is captured on DONE entry.
module div_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            resetn,
    div_iter_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_DZERO = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_b_mag;
    logic [WIDTH-1:0]   r_a_raw;
    logic               r_sign_q;
    logic               r_sign_r;
    logic [2*WIDTH-1:0] r_result;

    logic               w_start;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic               w_fit;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_fin_quo;
    logic [WIDTH-1:0]   w_fin_rem;
    logic [WIDTH-1:0]   w_res_quo;
    logic [WIDTH-1:0]   w_res_rem;
    logic               w_stall;

    assign w_start = bus.div_startE & ~bus.flushE;
    assign w_a_neg = bus.div_signedE & bus.srcaE[WIDTH-1];
    assign w_b_neg = bus.div_signedE & bus.srcbE[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~bus.srcaE + ONE) : bus.srcaE;
    assign w_b_mag = w_b_neg ? (~bus.srcbE + ONE) : bus.srcbE;

    // The shifted partial remainder needs one extra bit: with an unsigned
    // divisor near 2^WIDTH it can exceed WIDTH bits before the subtract.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_b_mag};
    assign w_fit      = ~w_trial[WIDTH];
    assign w_rem_next = w_fit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_fit};

    assign w_fin_quo = (r_state == S_DZERO) ? '1      : w_quo_next;
    assign w_fin_rem = (r_state == S_DZERO) ? r_a_raw : w_rem_next;
    assign w_res_quo = r_sign_q ? (~w_fin_quo + ONE) : w_fin_quo;
    assign w_res_rem = r_sign_r ? (~w_fin_rem + ONE) : w_fin_rem;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_b_mag  <= '0;
            r_a_raw  <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_result <= '0;
        end else if (bus.flushE) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_rem    <= '0;
                        r_quo    <= w_a_mag;
                        r_b_mag  <= w_b_mag;
                        r_a_raw  <= bus.srcaE;
                        r_sign_q <= w_a_neg ^ w_b_neg;
                        r_sign_r <= w_a_neg;
                        r_cnt    <= '0;
                        r_state  <= (bus.srcbE == '0) ? S_DZERO : S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST_CNT) begin
                        r_result <= {w_res_rem, w_res_quo};
                        r_state  <= S_DONE;
                    end
                end
                S_DZERO: begin
                    r_result <= {w_res_rem, w_res_quo};
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    // A frozen E still holds div_startE high; stay here so it is not re-run.
                    if (!bus.cache_stall) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_stall = 1'b0;
        if (resetn && !bus.flushE) begin
            case (r_state)
                S_IDLE:  w_stall = bus.div_startE;
                S_BUSY:  w_stall = 1'b1;
                S_DZERO: w_stall = 1'b1;
                default: w_stall = 1'b0;
            endcase
        end
    end

    assign bus.div_stall  = w_stall;
    assign bus.div_ready  = (r_state == S_DONE);
    assign bus.div_result = r_result;
endmodule
